// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the DMA request front end:
//   NUM_CH            channel count (fixed at 4)
//   *_ADDR            CPU register addresses (A3..A0) decoded by the request
//                     front end
//   chVec_t           one bit per channel
// ---------------------------------------------------------------------------
package dma_pkg;

   localparam int NUM_CH = 4;

   localparam logic [3:0] REQ_REG_ADDR     = 4'h9;
   localparam logic [3:0] SINGLE_MASK_ADDR = 4'hA;
   localparam logic [3:0] MASTER_CLR_ADDR  = 4'hD;
   localparam logic [3:0] CLR_MASK_ADDR    = 4'hE;
   localparam logic [3:0] ALL_MASK_ADDR    = 4'hF;

   typedef logic [NUM_CH-1:0] chVec_t;

endpackage

// File: rtl/dma_dreq_sync.sv
// ---------------------------------------------------------------------------
// dma_dreq_sync
// Per-bit DREQ synchroniser with synchronous active-high reset.
// Build option: DREQ_SYNC_EN
//   defined   -> STAGES-deep flop chain per bit (metastability protection)
//   undefined -> single capture register, STAGES ignored
// Ports:
//   clock     in   system clock
//   reset     in   synchronous active-high reset, clears all stages to 0
//   dreqRaw   in   WIDTH asynchronous request lines
//   dreqSync  out  WIDTH synchronised request lines
// ---------------------------------------------------------------------------
module dma_dreq_sync #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] dreqRaw,
   output logic [WIDTH-1:0] dreqSync
);

`ifdef DREQ_SYNC_EN

   logic [WIDTH-1:0] stageReg [STAGES];

   // Shift the raw requests through the chain; only the last stage is used
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            stageReg[k] <= '0;
         end
      end else begin
         stageReg[0] <= dreqRaw;
         for (int k = 1; k < STAGES; k++) begin
            stageReg[k] <= stageReg[k-1];
         end
      end
   end

   assign dreqSync = stageReg[STAGES-1];

`else

   localparam int unusedStages = STAGES;

   logic [WIDTH-1:0] captureReg;

   // Fully synchronous systems only need one capture register
   always_ff @(posedge clock) begin
      if (reset) begin
         captureReg <= '0;
      end else begin
         captureReg <= dreqRaw;
      end
   end

   assign dreqSync = captureReg;

`endif

endmodule

// File: rtl/dma_request_ctrl.sv
// ---------------------------------------------------------------------------
// dma_request_ctrl
// Request front end of the 4-channel DMA controller. Synchronises DREQ,
// applies sense polarity, mask and software request registers, and produces
// the qualified request vector for the priority logic plus status[7:4].
// Build option: DREQ_SYNC_EN (selects the synchroniser depth, see
// dma_dreq_sync).
// Ports:
//   CLK, RESET      clock, synchronous active-high reset
//   CS_N, IOW_N     chip select and write strobe, active low
//   A3..A0, DB      register address and write data
//   DREQ            asynchronous external channel requests
//   dreqSenseLow    1: DREQ is active low
//   ctrlDisable     blocks all qualified requests
//   tcEvent         one-cycle terminal-count pulse per channel
//   autoInit        autoinitialise bit per channel
//   validDREQ       qualified requests to priority logic
//   maskReg         current mask bits
//   requestReg      current software request bits
//   statusReq       status register bits [7:4]
// ---------------------------------------------------------------------------
module dma_request_ctrl
   import dma_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              CS_N,
   input  logic              IOW_N,
   input  logic              A3,
   input  logic              A2,
   input  logic              A1,
   input  logic              A0,
   input  logic [7:0]        DB,
   input  logic [NUM_CH-1:0] DREQ,
   input  logic              dreqSenseLow,
   input  logic              ctrlDisable,
   input  logic [NUM_CH-1:0] tcEvent,
   input  logic [NUM_CH-1:0] autoInit,
   output logic [NUM_CH-1:0] validDREQ,
   output logic [NUM_CH-1:0] maskReg,
   output logic [NUM_CH-1:0] requestReg,
   output logic [NUM_CH-1:0] statusReq
);

   logic              ioWnPrev;
   logic              wrStb;
   logic [3:0]        addr;
   logic [NUM_CH-1:0] syncDreq;
   logic [NUM_CH-1:0] sdreq;
   logic [NUM_CH-1:0] maskNext;
   logic [NUM_CH-1:0] requestNext;
   logic              unusedDb;

   assign addr     = {A3, A2, A1, A0};
   assign unusedDb = &{1'b0, DB[7:4]};

   // Single write per strobe: only the falling edge of IOW_N counts
   assign wrStb = !CS_N && !IOW_N && ioWnPrev;

   dma_dreq_sync #(
      .WIDTH  (NUM_CH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clock    (CLK),
      .reset    (RESET),
      .dreqRaw  (DREQ),
      .dreqSync (syncDreq)
   );

   // Sense polarity is applied after the synchroniser, so a polarity change
   // is seen immediately without resynchronisation
   assign sdreq = syncDreq ^ {NUM_CH{dreqSenseLow}};

   // CPU write decode first, then terminal count overrides the affected
   // bits so a TC on the same cycle as a write always wins
   always_comb begin
      maskNext    = maskReg;
      requestNext = requestReg;

      if (wrStb) begin
         case (addr)
            REQ_REG_ADDR:     requestNext[DB[1:0]] = DB[2];
            SINGLE_MASK_ADDR: maskNext[DB[1:0]]    = DB[2];
            MASTER_CLR_ADDR: begin
               maskNext    = '1;
               requestNext = '0;
            end
            CLR_MASK_ADDR:    maskNext = '0;
            ALL_MASK_ADDR:    maskNext = DB[NUM_CH-1:0];
            default: ;
         endcase
      end

      for (int i = 0; i < NUM_CH; i++) begin
         if (tcEvent[i]) begin
            requestNext[i] = 1'b0;
            if (!autoInit[i]) begin
               maskNext[i] = 1'b1;
            end
         end
      end
   end

   // Register state; reset matches master clear, and ioWnPrev resets high so
   // a strobe still held after reset is taken as a fresh write
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ioWnPrev   <= 1'b1;
         maskReg    <= '1;
         requestReg <= '0;
      end else begin
         ioWnPrev   <= IOW_N;
         maskReg    <= maskNext;
         requestReg <= requestNext;
      end
   end

   // Software requests bypass the mask; status ignores mask and disable
   assign validDREQ = ctrlDisable ? '0 : ((sdreq & ~maskReg) | requestReg);
   assign statusReq = sdreq | requestReg;

endmodule

// File: doc/dma_request_ctrl.md
# dma_request_ctrl

Request front end of the 4-channel DMA controller, directly upstream of the priority logic. Synchronises the external DREQ lines and applies DREQ sense polarity, the mask register and the software request register. Produces the qualified request vector consumed by priority logic, plus the request nibble of the status register. Owns the mask and request registers, including CPU writes, master clear and terminal-count auto-masking.

## Interface
Parameters:
- NUM_CH, 4, channel count; only 4 supported
- SYNC_STAGES, 2, DREQ synchroniser depth when DREQ_SYNC_EN is defined; legal values 2 and 3

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- CS_N  in  1  chip select, active low
- IOW_N  in  1  I/O write strobe, active low
- A3, A2, A1, A0  in  1 each  register address
- DB  in  8  CPU data bus (write data)
- DREQ  in  4  external channel requests, asynchronous
- dreqSenseLow  in  1  commandReg DREQ sense bit; 1 means DREQ is active low
- ctrlDisable  in  1  commandReg controller-disable bit
- tcEvent  in  4  one-cycle terminal-count pulse per channel, from datapath
- autoInit  in  4  modeReg autoinitialise bit per channel
- validDREQ  out  4  qualified requests to priority logic
- maskReg  out  4  current mask bits
- requestReg  out  4  current software request bits
- statusReq  out  4  status register bits [7:4]

## Operation
- Write detect:
  - wrStb = !CS_N & !IOW_N & ioWnPrev, where ioWnPrev is IOW_N registered with reset value 1.
  - Exactly one register update per strobe, regardless of strobe length.
- Decoded writes, with address A3..A0:
  - 4'h9 (request reg): requestReg[DB[1:0]] <= DB[2].
  - 4'hA (single mask): maskReg[DB[1:0]] <= DB[2].
  - 4'hD (master clear): maskReg <= 4'hF and requestReg <= 0. Same effect as RESET within this block.
  - 4'hE (clear mask): maskReg <= 4'h0.
  - 4'hF (write all mask): maskReg <= DB[3:0].
  - All other addresses: no effect.
- Terminal count, for each channel i with tcEvent[i]=1:
  - requestReg[i] <= 0.
  - If autoInit[i]=0, also maskReg[i] <= 1.
  - If autoInit[i]=1, the mask is unchanged.
- Simultaneous CPU write and tcEvent on the same bit: the tcEvent result wins. Writes to other bits proceed normally.
- Qualification, with sdreq = synchronised DREQ XOR dreqSenseLow:
  - validDREQ[i] = !ctrlDisable & ((sdreq[i] & !maskReg[i]) | requestReg[i]).
  - Software requests bypass the mask.
- statusReq[i] = sdreq[i] | requestReg[i]. Unmasked and unaffected by ctrlDisable.
- validDREQ and statusReq are combinational from registered state. There are no combinational paths from DREQ, DB or address inputs.

## Timing
- Reset values: maskReg=4'hF, requestReg=0, synchroniser flops=0, ioWnPrev=1. As a result, validDREQ=0 and statusReq=sdreq (DREQ sense applied to 0).
- DREQ to validDREQ/statusReq latency: SYNC_STAGES cycles with the macro, 1 cycle without. Deassertion has the same latency.
- Register writes are visible on outputs the cycle after the first strobe cycle.
- tcEvent is visible on outputs the cycle after the pulse.
- A dreqSenseLow change takes effect combinationally on the next evaluation. No resynchronisation is applied.
- RESET mid-strobe: the write is discarded. Because ioWnPrev resets to 1, a strobe still held low after reset releases is taken as a new write in the first post-reset cycle.

## Configuration
- DREQ_SYNC_EN defined: DREQ passes through SYNC_STAGES flops (metastability protection).
- DREQ_SYNC_EN undefined: a single capture register, for 1-cycle latency in fully synchronous systems. SYNC_STAGES is ignored.

## Structure
- dma_pkg holds:
  - NUM_CH.
  - Address constants: REQ_REG_ADDR=4'h9, SINGLE_MASK_ADDR=4'hA, MASTER_CLR_ADDR=4'hD, CLR_MASK_ADDR=4'hE, ALL_MASK_ADDR=4'hF.
  - A typedef for the 4-bit channel vector.
- Sub-module dma_dreq_sync: parameterised per-bit synchroniser chain with synchronous reset. It contains the DREQ_SYNC_EN conditional.
- Mask/request register logic and qualification stay in dma_request_ctrl.

## Test plan
- Reset release with DREQ=4'hF, dreqSenseLow=0 → validDREQ=0 (all masked) and statusReq=4'hF after 2 cycles. Write 4'hE → validDREQ=4'hF on the following cycle.
- Write addr 4'hA with DB=8'h05 (ch1 mask set) after clear mask, DREQ=4'h3 → validDREQ=4'h1. Write DB=8'h01 → validDREQ=4'h3.
- Write addr 4'h9 with DB=8'h06 (ch2 request) and all masked, DREQ=0 → validDREQ=4'h4, statusReq=4'h4. Then tcEvent=4'h4, autoInit=0 → validDREQ=0, maskReg=4'hF, requestReg=0.
- Mask cleared, DREQ=4'h1, tcEvent[0] with autoInit[0]=1 → maskReg[0] stays 0 and validDREQ[0] stays 1. Repeat with autoInit[0]=0 → maskReg[0]=1 and validDREQ=0.
- Hold IOW_N low for 5 cycles on addr 4'h9 with DB=8'h04, while tcEvent[0] pulses in cycle 3 → requestReg[0]=0 with a single write effect. Master clear 4'hD → maskReg=4'hF, requestReg=0.
- dreqSenseLow=1, DREQ=4'hE, mask cleared → validDREQ=4'h1. ctrlDisable=1 → validDREQ=0 while statusReq stays 4'h1.
